// File: rtl/ethernetsystem_sdram_ex_checker_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ethernetsystem_sdram_ex_checker_pkg
// Purpose  : Shared state encoding and LFSR helpers for the SDRAM pattern checker
// Revision : 1.0 - initial release
// ============================================================================
package ethernetsystem_sdram_ex_checker_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        DONE  = 2'd2
    } state_t;

    // One step of the 8-bit pattern LFSR; bit 7 feeds back into taps 0, 2, 3 and 4.
    function automatic logic [7:0] lfsr8_step(input logic [7:0] d);
        return {d[6], d[5], d[4], d[3] ^ d[7], d[2] ^ d[7], d[1] ^ d[7], d[0], d[7]};
    endfunction

    function automatic logic [7:0] lane_seed(input int unsigned seed, input int unsigned idx);
        logic [31:0] s;
        s = seed + idx;
        return s[7:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/ethernetsystem_sdram_ex_chk_lane.sv
`default_nettype none
// ============================================================================
// Module   : ethernetsystem_sdram_ex_chk_lane
// Purpose  : One byte lane of the expected-pattern generator (8-bit LFSR)
// Revision : 1.0 - initial release
// ============================================================================
module ethernetsystem_sdram_ex_chk_lane
    import ethernetsystem_sdram_ex_checker_pkg::*;
#(
    parameter logic [7:0] SEED_VAL = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic       advance,
    output logic [7:0] value
);

    always_ff @(posedge clk) begin
        if (reset || load) begin
            value <= SEED_VAL;
        end else if (advance) begin
            value <= lfsr8_step(value);
        end
    end

endmodule
`default_nettype wire

// File: rtl/ethernetsystem_sdram_ex_checker.sv
`default_nettype none
// ============================================================================
// Module   : ethernetsystem_sdram_ex_checker
// Purpose  : Checks SDRAM read-back data against a regenerated LFSR pattern
// Revision : 1.0 - initial release
// ============================================================================
module ethernetsystem_sdram_ex_checker
    import ethernetsystem_sdram_ex_checker_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int SEED          = 32,
    parameter int CNT_WIDTH     = 16,
    parameter int ERR_CNT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [CNT_WIDTH-1:0]     expected_count,
    input  logic                     rdata_valid,
    input  logic [DATA_WIDTH-1:0]    rdata,
    output logic                     busy,
    output logic                     done,
    output logic                     pass,
    output logic [ERR_CNT_WIDTH-1:0] err_count,
    output logic                     err_flag,
    output logic [CNT_WIDTH-1:0]     first_err_index,
    output logic [DATA_WIDTH-1:0]    first_err_data,
    output logic [DATA_WIDTH-1:0]    first_err_expected,
    output logic                     extra_data
);

    localparam int NUM_LANES = DATA_WIDTH / 8;
    localparam logic [CNT_WIDTH-1:0]     c_cnt_one = CNT_WIDTH'(1);
    localparam logic [ERR_CNT_WIDTH-1:0] c_err_one = ERR_CNT_WIDTH'(1);
    localparam logic [ERR_CNT_WIDTH-1:0] c_err_max = {ERR_CNT_WIDTH{1'b1}};

    state_t                r_state;
    logic [CNT_WIDTH-1:0]  r_count;
    logic [CNT_WIDTH-1:0]  r_target;
    logic [DATA_WIDTH-1:0] w_expected;
    logic [CNT_WIDTH-1:0]  w_count_next;
    logic                  w_beat;
    logic                  w_mismatch;

    // A start in the same cycle as a beat takes priority; that beat is dropped.
    assign w_beat       = (r_state == CHECK) && rdata_valid && !start;
    assign w_mismatch   = (rdata != w_expected);
    assign w_count_next = r_count + c_cnt_one;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        ethernetsystem_sdram_ex_chk_lane #(
            .SEED_VAL (lane_seed(SEED, g))
        ) u_lane (
            .clk     (clk),
            .reset   (reset),
            .load    (start),
            .advance (w_beat),
            .value   (w_expected[g*8 +: 8])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state            <= IDLE;
            r_count            <= '0;
            r_target           <= '0;
            busy               <= 1'b0;
            done               <= 1'b0;
            pass               <= 1'b0;
            err_count          <= '0;
            err_flag           <= 1'b0;
            first_err_index    <= '0;
            first_err_data     <= '0;
            first_err_expected <= '0;
            extra_data         <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                r_count            <= '0;
                r_target           <= expected_count;
                err_count          <= '0;
                err_flag           <= 1'b0;
                first_err_index    <= '0;
                first_err_data     <= '0;
                first_err_expected <= '0;
                extra_data         <= 1'b0;
                if (expected_count == '0) begin
                    r_state <= DONE;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    pass    <= 1'b1;
                end else begin
                    r_state <= CHECK;
                    busy    <= 1'b1;
                    pass    <= 1'b0;
                end
            end else begin
                if (rdata_valid && (r_state != CHECK)) begin
                    extra_data <= 1'b1;
                end
                if (w_beat) begin
                    r_count <= w_count_next;
                    if (w_mismatch) begin
                        err_flag <= 1'b1;
                        if (err_count != c_err_max) begin
                            err_count <= err_count + c_err_one;
                        end
                        if (!err_flag) begin
                            first_err_index    <= r_count;
                            first_err_data     <= rdata;
                            first_err_expected <= w_expected;
                        end
                    end
                    // Final beat: the verdict includes this beat's own compare.
                    if (w_count_next == r_target) begin
                        r_state <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        pass    <= !(err_flag || w_mismatch);
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ethernetsystem_sdram_ex_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_ethernetsystem_sdram_ex_checker
// Purpose  : Directed self-checking bench for the SDRAM pattern checker
// Revision : 1.0 - initial release
// ============================================================================
module tb_ethernetsystem_sdram_ex_checker;

    localparam logic [31:0] c_w0 = 32'h23222120;
    localparam logic [31:0] c_w1 = 32'h46444240;
    localparam logic [31:0] c_w2 = 32'h8C888480;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [15:0] expected_count = '0;
    logic        rdata_valid = 1'b0;
    logic [31:0] rdata = '0;

    logic        busy, done, pass, err_flag, extra_data;
    logic [15:0] err_count, first_err_index;
    logic [31:0] first_err_data, first_err_expected;

    logic        busy2, done2, pass2, err_flag2, extra_data2;
    logic [1:0]  err_count2;
    logic [15:0] first_err_index2;
    logic [31:0] first_err_data2, first_err_expected2;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    ethernetsystem_sdram_ex_checker #(
        .DATA_WIDTH(32), .SEED(32), .CNT_WIDTH(16), .ERR_CNT_WIDTH(16)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .expected_count(expected_count),
        .rdata_valid(rdata_valid), .rdata(rdata), .busy(busy), .done(done),
        .pass(pass), .err_count(err_count), .err_flag(err_flag),
        .first_err_index(first_err_index), .first_err_data(first_err_data),
        .first_err_expected(first_err_expected), .extra_data(extra_data)
    );

    // Narrow error counter to exercise saturation; shares all inputs.
    ethernetsystem_sdram_ex_checker #(
        .DATA_WIDTH(32), .SEED(32), .CNT_WIDTH(16), .ERR_CNT_WIDTH(2)
    ) dut_sat (
        .clk(clk), .reset(reset), .start(start), .expected_count(expected_count),
        .rdata_valid(rdata_valid), .rdata(rdata), .busy(busy2), .done(done2),
        .pass(pass2), .err_count(err_count2), .err_flag(err_flag2),
        .first_err_index(first_err_index2), .first_err_data(first_err_data2),
        .first_err_expected(first_err_expected2), .extra_data(extra_data2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [15:0] cnt);
        start = 1'b1;
        expected_count = cnt;
        tick();
        start = 1'b0;
    endtask

    task automatic beat(input logic [31:0] d);
        rdata_valid = 1'b1;
        rdata = d;
        tick();
        rdata_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tests_run++;
        if ({busy, done, pass, err_flag, extra_data} !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_flags: got busy/done/pass/err_flag/extra=%b, want 00000",
                     {busy, done, pass, err_flag, extra_data});
        end
        tests_run++;
        if (err_count !== 16'd0) begin
            tests_failed++;
            $display("FAIL reset_err_count: got %0d, want 0", err_count);
        end
    endtask

    task automatic test_clean();
        do_start(16'd3);
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL clean_busy: got %b, want 1", busy);
        end
        beat(c_w0);
        beat(c_w1);
        tests_run++;
        if (done !== 1'b0) begin
            tests_failed++;
            $display("FAIL clean_early_done: got %b, want 0", done);
        end
        beat(c_w2);
        tests_run++;
        if ({done, pass, busy, err_flag} !== 4'b1100 || err_count !== 16'd0) begin
            tests_failed++;
            $display("FAIL clean_result: got done/pass/busy/err=%b cnt=%0d, want 1100 cnt=0",
                     {done, pass, busy, err_flag}, err_count);
        end
        tick();
        tests_run++;
        if (done !== 1'b0 || pass !== 1'b1) begin
            tests_failed++;
            $display("FAIL clean_done_pulse: got done=%b pass=%b, want done=0 pass=1", done, pass);
        end
    endtask

    task automatic test_single_error();
        do_start(16'd3);
        beat(c_w0);
        beat(32'h46444241);
        tests_run++;
        if (err_count !== 16'd1 || first_err_index !== 16'd1) begin
            tests_failed++;
            $display("FAIL err_latency: got cnt=%0d idx=%0d, want cnt=1 idx=1", err_count, first_err_index);
        end
        beat(c_w2);
        tests_run++;
        if ({done, pass, err_flag} !== 3'b101 || err_count !== 16'd1) begin
            tests_failed++;
            $display("FAIL err_result: got done/pass/err=%b cnt=%0d, want 101 cnt=1",
                     {done, pass, err_flag}, err_count);
        end
        tests_run++;
        if (first_err_data !== 32'h46444241 || first_err_expected !== 32'h46444240) begin
            tests_failed++;
            $display("FAIL err_capture: got data=%h exp=%h, want 46444241 46444240",
                     first_err_data, first_err_expected);
        end
    endtask

    task automatic test_gapped();
        logic busy_ok;
        logic done_seen;
        busy_ok = 1'b1;
        done_seen = 1'b0;
        do_start(16'd3);
        beat(c_w0);
        for (int i = 0; i < 2; i++) begin
            busy_ok &= busy; done_seen |= done; tick();
        end
        beat(c_w1);
        for (int i = 0; i < 2; i++) begin
            busy_ok &= busy; done_seen |= done; tick();
        end
        busy_ok &= busy;
        beat(c_w2);
        tests_run++;
        if (busy_ok !== 1'b1 || done_seen !== 1'b0) begin
            tests_failed++;
            $display("FAIL gap_busy: got busy_held=%b early_done=%b, want 1 0", busy_ok, done_seen);
        end
        tests_run++;
        if ({done, pass, err_flag} !== 3'b110 || err_count !== 16'd0) begin
            tests_failed++;
            $display("FAIL gap_result: got done/pass/err=%b cnt=%0d, want 110 cnt=0",
                     {done, pass, err_flag}, err_count);
        end
    endtask

    task automatic test_zero_count();
        do_start(16'd0);
        tests_run++;
        if ({done, pass, busy} !== 3'b110) begin
            tests_failed++;
            $display("FAIL zero_count: got done/pass/busy=%b, want 110", {done, pass, busy});
        end
    endtask

    task automatic test_extra_data();
        tick();
        beat(32'h12345678);
        tests_run++;
        if (extra_data !== 1'b1 || err_count !== 16'd0 || pass !== 1'b1) begin
            tests_failed++;
            $display("FAIL extra_in_done: got extra=%b cnt=%0d pass=%b, want 1 0 1",
                     extra_data, err_count, pass);
        end
        // start with a simultaneous beat: start clears and the beat is dropped
        rdata_valid = 1'b1;
        rdata = 32'hFFFFFFFF;
        do_start(16'd3);
        rdata_valid = 1'b0;
        tests_run++;
        if (extra_data !== 1'b0 || busy !== 1'b1 || err_count !== 16'd0) begin
            tests_failed++;
            $display("FAIL start_wins: got extra=%b busy=%b cnt=%0d, want 0 1 0", extra_data, busy, err_count);
        end
        beat(c_w0);
        beat(c_w1);
        beat(c_w2);
        tests_run++;
        if ({done, pass} !== 2'b11) begin
            tests_failed++;
            $display("FAIL start_wins_run: got done/pass=%b, want 11", {done, pass});
        end
    endtask

    task automatic test_saturation();
        do_start(16'd5);
        for (int i = 0; i < 5; i++) beat(32'h0);
        tests_run++;
        if (err_count2 !== 2'd3 || err_count !== 16'd5) begin
            tests_failed++;
            $display("FAIL err_saturate: got narrow=%0d wide=%0d, want 3 5", err_count2, err_count);
        end
        tests_run++;
        if ({done2, pass2, first_err_index2} !== {2'b10, 16'd0} || first_err_expected2 !== c_w0) begin
            tests_failed++;
            $display("FAIL sat_result: got done/pass=%b idx=%0d exp=%h, want 10 0 %h",
                     {done2, pass2}, first_err_index2, first_err_expected2, c_w0);
        end
    endtask

    task automatic test_abort_reset();
        logic done_seen;
        do_start(16'd3);
        beat(32'hDEADBEEF);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tests_run++;
        if ({busy, done, pass, err_flag, extra_data} !== 5'b0 || err_count !== 16'd0
            || first_err_data !== 32'd0 || first_err_index !== 16'd0) begin
            tests_failed++;
            $display("FAIL abort_reset: got flags=%b cnt=%0d fdata=%h, want 00000 0 0",
                     {busy, done, pass, err_flag, extra_data}, err_count, first_err_data);
        end
        done_seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(); done_seen |= done;
        end
        tests_run++;
        if (done_seen !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_no_done: got done_seen=%b, want 0", done_seen);
        end
    endtask

    task automatic test_restart();
        do_start(16'd3);
        beat(32'hDEADBEEF);
        do_start(16'd3);
        tests_run++;
        if (err_flag !== 1'b0 || busy !== 1'b1 || err_count !== 16'd0) begin
            tests_failed++;
            $display("FAIL restart_clear: got err=%b busy=%b cnt=%0d, want 0 1 0", err_flag, busy, err_count);
        end
        beat(c_w0);
        beat(c_w1);
        beat(c_w2);
        tests_run++;
        if ({done, pass, err_flag} !== 3'b110) begin
            tests_failed++;
            $display("FAIL restart_result: got done/pass/err=%b, want 110", {done, pass, err_flag});
        end
    endtask

    initial begin
        test_reset();
        test_clean();
        test_single_error();
        test_gapped();
        test_zero_count();
        test_extra_data();
        test_saturation();
        test_abort_reset();
        test_restart();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
